ysyx_22041412_lsu: RTL and testbench
====================================

# ysyx_22041412_lsu

Load/store unit for the RV64 NPC core, directly downstream of the ALU in the execute path. It takes the ALU result as the effective address, or as a pass-through value for non-memory ops. It issues one aligned 64-bit memory transaction per load/store over a valid/ready bus. It then returns a sign- or zero-extended load result, or the forwarded ALU result, to writeback through a registered valid/ready output.

## Interface
- No parameters; data width fixed at 64 bits.
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  EX stage presents an operation.
- `in_ready`  out  1  LSU can accept an operation (high only in IDLE).
- `in_opcode`  in  7  instruction opcode (load, store, or other).
- `in_func3`  in  3  width/sign selector.
- `in_result`  in  64  ALU result: effective address for load/store, value otherwise.
- `in_wdata`  in  64  store data (rs2).
- `in_rd`  in  5  destination register.
- `mem_req_valid`  out  1  memory request pending.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_addr`  out  64  request address, bits [2:0] forced to 0.
- `mem_wen`  out  1  1 = store, 0 = load.
- `mem_wdata`  out  64  lane-shifted store data.
- `mem_wmask`  out  8  byte-enable mask.
- `mem_rsp_valid`  in  1  response: read data for loads, write ack for stores.
- `mem_rdata`  in  64  aligned read data.
- `out_valid`  out  1  result available to WB.
- `out_ready`  in  1  WB consumes the result.
- `out_data`  out  64  writeback value (0 for stores).
- `out_rd`  out  5  destination register (0 for stores).
- `out_wen`  out  1  register write enable (0 for stores).
- `out_exc`  out  1  misaligned-access flag (see Configuration).

## Operation
- FSM states:
  - IDLE→REQ on accepted load/store.
  - IDLE→DONE on accepted non-memory op.
  - REQ→WAIT on `mem_req_valid && mem_req_ready`.
  - WAIT→DONE on `mem_rsp_valid`.
  - DONE→IDLE on `out_ready`.
- Accept: `in_valid && in_ready`; all inputs are captured into internal registers that cycle.
- Request fields (`mem_addr`, `mem_wen`, `mem_wdata`, `mem_wmask`) are held stable while `mem_req_valid` is high.
- Store mask:
  - Size mask by func3: 000→0x01, 001→0x03, 010→0x0F, 011→0xFF.
  - `mem_wmask` = size mask << addr[2:0], truncated to 8 bits.
  - `mem_wdata` = `in_wdata` << (addr[2:0]*8).
- Load extraction:
  - Shift `mem_rdata` right by addr[2:0]*8.
  - Sign-extend for func3 000/001/010 (lb/lh/lw).
  - Pass through for 011 (ld).
  - Zero-extend for 100/101/110 (lbu/lhu/lwu).
  - func3 111 yields 0.
- The extracted load value is registered into `out_data` on the WAIT→DONE transition.
- Non-memory op: `out_data` = `in_result`, `out_wen` = 1.
- Store completion: `out_wen` = 0, `out_data` = 0.
- Outputs are held stable in DONE until `out_ready`.

## Timing
- Reset values: state IDLE; `in_ready` = 1; `mem_req_valid`, `mem_wen`, `out_valid`, `out_wen`, `out_exc` = 0; all data/address/mask/rd outputs = 0.
- Non-memory op: accepted at cycle N, `out_valid` at N+1.
- Memory op, best case: accepted at N; `mem_req_valid` at N+1 (ready that cycle); `mem_rsp_valid` at N+2; `out_valid` at N+3.
- `mem_rsp_valid` in any state other than WAIT is ignored.
- A response in the same cycle as request acceptance is not legal on this bus.
- `in_ready` is 0 from the accept cycle+1 through the DONE handoff. IDLE is re-entered the cycle after `out_valid && out_ready`, so back-to-back throughput is one op per 2 cycles minimum.
- Reset asserted mid-transaction: immediate return to IDLE, `mem_req_valid` drops combinationally with reset, and an outstanding response is dropped.

## Configuration
- Macro: `YSYX_22041412_LSU_MISALIGN_EN`.
- Defined:
  - Misalignment is checked: halfword with addr[0]≠0, word with addr[1:0]≠0, doubleword with addr[2:0]≠0.
  - A misaligned access goes IDLE→DONE with no memory request, `out_exc` = 1, `out_wen` = 0, `out_data` = address.
- Undefined:
  - No check; `out_exc` is tied to 0.
  - The access is issued with the mask truncated to 8 bits, so bytes beyond the doubleword are silently dropped.

## Structure
- Opcode constants (load, store) and func3 width encodings belong in the shared define header alongside the existing ALU constants.
- FSM state encodings are local to the LSU.
- Sub-module `ysyx_22041412_lsu_align`: purely combinational, holding the store lane shift/mask generation and the load shift/extension. It is shared by the FSM datapath and testable in isolation.

## Test plan
- lb at addr 0x8000_0003, `mem_rdata` = 0x0000_0000_8000_0000 → `out_data` = 0xFFFF_FFFF_FFFF_FF80, `out_wen` = 1, `out_valid` 3 cycles after accept with zero-wait memory.
- sh at addr 0x8000_0006, `in_wdata` = 0x1234 → `mem_wmask` = 0xC0, `mem_wdata` = 0x1234_0000_0000_0000, `mem_addr` = 0x8000_0000; `out_wen` = 0.
- lwu at addr 0x4, `mem_rdata` = 0xDEAD_BEEF_0000_0000 → `out_data` = 0x0000_0000_DEAD_BEEF.
- Non-memory op with `in_result` = 0x55, `out_ready` held low for 4 cycles → `out_valid` stays high with data stable, and `in_ready` stays 0 until the handoff.
- `mem_req_ready` low for 3 cycles, then reset pulsed while in WAIT → all outputs return to reset values, and a subsequent `mem_rsp_valid` produces no `out_valid`.
- With the macro defined, lw at addr 0x2 → no `mem_req_valid`, `out_exc` = 1 at accept+1, `out_data` = 0x2.

Source files
------------

// File: rtl/ysyx_22041412_lsu_pkg.sv
// Shared LSU/ALU constants: RV64 opcodes, func3 width encodings, captured-op record.
// Latency: none (declarations only).
// Backpressure: n/a.
package ysyx_22041412_lsu_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } kind_e;

    // Everything the LSU needs about an accepted operation.
    typedef struct packed {
        kind_e       kind;
        logic [2:0]  func3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [4:0]  rd;
    } op_t;

    function automatic kind_e decode_kind(input logic [6:0] opcode);
        case (opcode)
            OPC_LOAD:  return KIND_LOAD;
            OPC_STORE: return KIND_STORE;
            default:   return KIND_ALU;
        endcase
    endfunction

    // Natural alignment by access width (func3[1:0] encodes log2 of bytes).
    function automatic logic misaligned(input logic [2:0] func3, input logic [2:0] off);
        case (func3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane alignment: store shift/mask generation and load shift/extension.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module ysyx_22041412_lsu_align
    import ysyx_22041412_lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [2:0]  offset,
    input  logic [63:0] st_data,
    input  logic [63:0] ld_raw,
    output logic [63:0] st_lane,
    output logic [7:0]  st_mask,
    output logic [63:0] ld_value
);

    logic [5:0]  bit_shift;
    logic [7:0]  size_mask;
    logic [63:0] ld_shift;

    assign bit_shift = {offset, 3'b000};

    // Store side: size mask moved onto the addressed lanes; bytes past lane 7 fall off.
    always_comb begin
        size_mask = 8'h00;
        case (func3)
            F3_B:    size_mask = 8'h01;
            F3_H:    size_mask = 8'h03;
            F3_W:    size_mask = 8'h0F;
            F3_D:    size_mask = 8'hFF;
            default: size_mask = 8'h00;
        endcase
        st_mask = size_mask << offset;
        st_lane = st_data << bit_shift;
    end

    // Load side: bring the addressed byte to lane 0, then extend by width/sign.
    always_comb begin
        ld_shift = ld_raw >> bit_shift;
        ld_value = 64'd0;
        case (func3)
            F3_B:    ld_value = {{56{ld_shift[7]}},  ld_shift[7:0]};
            F3_H:    ld_value = {{48{ld_shift[15]}}, ld_shift[15:0]};
            F3_W:    ld_value = {{32{ld_shift[31]}}, ld_shift[31:0]};
            F3_D:    ld_value = ld_shift;
            F3_BU:   ld_value = {56'd0, ld_shift[7:0]};
            F3_HU:   ld_value = {48'd0, ld_shift[15:0]};
            F3_WU:   ld_value = {32'd0, ld_shift[31:0]};
            default: ld_value = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// Load/store unit: one aligned 64-bit bus transaction per load/store, ALU pass-through otherwise.
// Latency: non-memory op 1 cycle to out_valid; memory op 3 cycles best case (grows with bus stalls).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Option: YSYX_22041412_LSU_MISALIGN_EN.
module ysyx_22041412_lsu
    import ysyx_22041412_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_func3,
    input  logic [63:0] in_result,
    input  logic [63:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_addr,
    output logic        mem_wen,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_exc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e      state_q, state_d;
    op_t         op_q;
    kind_e       in_kind;
    logic        in_misalign;
    logic        accept;
    logic        go_done;
    logic        rsp_done;
    logic        is_store;
    logic [63:0] st_lane;
    logic [7:0]  st_mask;
    logic [63:0] ld_value;

    assign in_kind  = decode_kind(in_opcode);
    assign accept   = in_valid && in_ready;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
    assign in_misalign = (in_kind != KIND_ALU) && misaligned(in_func3, in_result[2:0]);
`else
    assign in_misalign = 1'b0;
`endif
    // Ops that finish without touching the bus.
    assign go_done  = accept && ((in_kind == KIND_ALU) || in_misalign);
    assign rsp_done = (state_q == S_WAIT) && mem_rsp_valid;
    assign is_store = (op_q.kind == KIND_STORE);

    ysyx_22041412_lsu_align u_align (
        .func3    (op_q.func3),
        .offset   (op_q.addr[2:0]),
        .st_data  (op_q.wdata),
        .ld_raw   (mem_rdata),
        .st_lane  (st_lane),
        .st_mask  (st_mask),
        .ld_value (ld_value)
    );

    // Request fields come straight from the captured op, so they are stable through REQ.
    assign mem_addr  = {op_q.addr[63:3], 3'b000};
    assign mem_wen   = is_store;
    assign mem_wdata = is_store ? st_lane : 64'd0;
    assign mem_wmask = is_store ? st_mask : 8'h00;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state and handshake outputs; mem_req_valid is masked by reset directly.
    always_comb begin
        state_d       = state_q;
        in_ready      = 1'b0;
        mem_req_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = go_done ? S_DONE : S_REQ;
            end
            S_REQ: begin
                mem_req_valid = !rst;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: if (mem_rsp_valid) state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operation capture and registered writeback result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            out_valid <= 1'b0;
            out_data  <= 64'd0;
            out_rd    <= 5'd0;
            out_wen   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= '{kind: in_kind, func3: in_func3, addr: in_result,
                          wdata: in_wdata, rd: in_rd};
            end
            if (go_done) begin
                out_valid <= 1'b1;
                out_data  <= in_result;
                out_rd    <= in_misalign ? 5'd0 : in_rd;
                out_wen   <= !in_misalign;
            end else if (rsp_done) begin
                out_valid <= 1'b1;
                out_data  <= is_store ? 64'd0 : ld_value;
                out_rd    <= is_store ? 5'd0 : op_q.rd;
                out_wen   <= !is_store;
            end else if ((state_q == S_DONE) && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef YSYX_22041412_LSU_MISALIGN_EN
    logic exc_q;
    // Exception flag tracks whichever result is being presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           exc_q <= 1'b0;
        else if (go_done)  exc_q <= in_misalign;
        else if (rsp_done) exc_q <= 1'b0;
    end
    assign out_exc = exc_q;
`else
    assign out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Scoreboard bench for the LSU: random ops against a byte-level reference model plus directed cases.
// Latency: checks 1-cycle ALU and 3-cycle best-case memory paths.
// Backpressure: randomizes mem_req_ready, response delay and out_ready.
module tb_ysyx_22041412_lsu;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_func3 = '0;
    logic [63:0] in_result = '0;
    logic [63:0] in_wdata = '0;
    logic [4:0]  in_rd = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [63:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_exc;

    ysyx_22041412_lsu dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_func3(in_func3), .in_result(in_result), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_exc(out_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        wen;
        logic        exc;
    } res_t;

    req_t        exp_req[$];
    logic [63:0] exp_rdata[$];
    res_t        exp_out[$];

    int vectors = 0;
    int miscompares = 0;

    bit auto_mem = 1'b1;
    bit auto_out = 1'b1;
    bit rand_ready = 1'b0;
    int extra_max = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_req(input logic [63:0] a, input logic w, input logic [63:0] d,
                            input logic [7:0] m, input logic [63:0] rdat);
        req_t r;
        r.addr = a; r.wen = w; r.wdata = d; r.mask = m;
        exp_req.push_back(r);
        exp_rdata.push_back(rdat);
    endtask

    task automatic push_out(input logic [63:0] d, input logic [4:0] rd, input logic w, input logic e);
        res_t o;
        o.data = d; o.rd = rd; o.wen = w; o.exc = e;
        exp_out.push_back(o);
    endtask

    // Reference model: byte arithmetic on widths, independent of the lane hardware.
    task automatic model(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rdat, input logic [4:0] rd);
        int          off;
        int          n;
        int          m;
        logic [63:0] sh;
        logic [63:0] keep;
        logic [63:0] val;
        bit          mis;
        off = int'(addr[2:0]);
        n = 1 << f3[1:0];
        mis = 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
        if ((opc == OPC_LOAD || opc == OPC_STORE) && (off % n) != 0) mis = 1'b1;
`endif
        if (opc != OPC_LOAD && opc != OPC_STORE) begin
            push_out(addr, rd, 1'b1, 1'b0);
        end else if (mis) begin
            push_out(addr, 5'd0, 1'b0, 1'b1);
        end else if (opc == OPC_STORE) begin
            m = ((1 << n) - 1) << off;
            push_req({addr[63:3], 3'b000}, 1'b1, wd << (8 * off), m[7:0], rdat);
            push_out(64'd0, 5'd0, 1'b0, 1'b0);
        end else begin
            sh = rdat >> (8 * off);
            keep = (n == 8) ? {64{1'b1}} : ((64'd1 << (8 * n)) - 64'd1);
            val = sh & keep;
            if (f3 == 3'b111) val = 64'd0;
            else if (!f3[2] && n < 8 && val[8 * n - 1]) val = val | ~keep;
            push_req({addr[63:3], 3'b000}, 1'b0, 64'd0, 8'h00, rdat);
            push_out(val, rd, 1'b1, 1'b0);
        end
    endtask

    // Memory side: random ready, request check against scoreboard, delayed response.
    initial begin : responder
        int          rsp_cnt;
        logic [63:0] rsp_data;
        req_t        r;
        rsp_cnt = 0;
        rsp_data = '0;
        forever begin
            @(negedge clk);
            if (auto_mem) begin
                mem_rsp_valid = 1'b0;
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rsp_valid = 1'b1;
                        mem_rdata = rsp_data;
                    end
                end
                mem_req_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
                #2;
                if (mem_req_valid && mem_req_ready) begin
                    if (exp_req.size() == 0) begin
                        chk("unexpected_req", 64'd1, 64'd0);
                        rsp_data = '0;
                    end else begin
                        r = exp_req.pop_front();
                        rsp_data = exp_rdata.pop_front();
                        chk("mem_addr", mem_addr, r.addr);
                        chk("mem_wen", 64'(mem_wen), 64'(r.wen));
                        chk("mem_wdata", mem_wdata, r.wdata);
                        chk("mem_wmask", 64'(mem_wmask), 64'(r.mask));
                    end
                    rsp_cnt = 1 + ((extra_max > 0) ? $urandom_range(0, extra_max) : 0);
                end
            end
        end
    end

    // Writeback side: every cycle out_valid is high the outputs must equal the queue head.
    initial begin : out_mon
        res_t e;
        forever begin
            @(negedge clk);
            if (auto_out) out_ready = ($urandom_range(0, 1) == 1);
            #2;
            if (out_valid) begin
                if (exp_out.size() == 0) begin
                    chk("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_out[0];
                    chk("out_data", out_data, e.data);
                    chk("out_rd", 64'(out_rd), 64'(e.rd));
                    chk("out_wen", 64'(out_wen), 64'(e.wen));
                    chk("out_exc", 64'(out_exc), 64'(e.exc));
                    if (out_ready) void'(exp_out.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] res,
                         input logic [63:0] wd, input logic [4:0] rd);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = opc; in_func3 = f3;
        in_result = res; in_wdata = wd; in_rd = rd;
        #2;
        while (!in_ready && guard < 200) begin
            @(negedge clk); #2; guard++;
        end
        if (guard >= 200) chk("accept_timeout", 64'd1, 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge of cycle accept+1; counts cycles until out_valid.
    task automatic wait_out(input string name, input int exp_lat);
        int n;
        n = 1;
        #2;
        while (!out_valid && n < 50) begin
            @(negedge clk); #2; n++;
        end
        chk(name, 64'(n), 64'(exp_lat));
    endtask

    task automatic drain(input string name);
        int g;
        g = 0;
        while ((exp_out.size() != 0 || !in_ready) && g < 500) begin
            @(negedge clk); #3; g++;
        end
        chk(name, 64'(exp_out.size()), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_req_valid"}, 64'(mem_req_valid), 64'd0);
        chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
        chk({tag, "_mem_addr"}, mem_addr, 64'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 64'd0);
        chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_wen"}, 64'(out_wen), 64'd0);
        chk({tag, "_out_exc"}, 64'(out_exc), 64'd0);
        chk({tag, "_out_data"}, out_data, 64'd0);
        chk({tag, "_out_rd"}, 64'(out_rd), 64'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin : main
        logic [63:0] a, wd, rdat;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;

        repeat (2) @(negedge clk);
        check_idle("reset");
        #3; rst = 1'b0;

        // lb sign-extension and best-case latency
        push_req(64'h8000_0000, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8000_0000);
        push_out(64'hFFFF_FFFF_FFFF_FF80, 5'd5, 1'b1, 1'b0);
        issue(OPC_LOAD, 3'b000, 64'h8000_0003, 64'd0, 5'd5);
        wait_out("lb_latency", 3);
        drain("lb_drain");

        // sh lane placement
        push_req(64'h8000_0000, 1'b1, 64'h1234_0000_0000_0000, 8'hC0, 64'd0);
        push_out(64'd0, 5'd0, 1'b0, 1'b0);
        issue(OPC_STORE, 3'b001, 64'h8000_0006, 64'h1234, 5'd9);
        drain("sh_drain");

        // lwu zero-extension
        push_req(64'h0, 1'b0, 64'd0, 8'h00, 64'hDEAD_BEEF_0000_0000);
        push_out(64'h0000_0000_DEAD_BEEF, 5'd3, 1'b1, 1'b0);
        issue(OPC_LOAD, 3'b110, 64'h4, 64'd0, 5'd3);
        drain("lwu_drain");

        // func3 111 load returns zero
        push_req(64'h100, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        push_out(64'd0, 5'd4, 1'b1, 1'b0);
        issue(OPC_LOAD, 3'b111, 64'h100, 64'd0, 5'd4);
        drain("f3_111_drain");

        // Non-memory op held under out_ready low
        @(negedge clk); #3; auto_out = 1'b0;
        @(negedge clk); out_ready = 1'b0;
        push_out(64'h55, 5'd1, 1'b1, 1'b0);
        issue(OPC_ALU, 3'b000, 64'h55, 64'd0, 5'd1);
        wait_out("alu_latency", 1);
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            @(negedge clk); #2;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk); #2;
        chk("handoff_in_ready", 64'(in_ready), 64'd1);
        chk("handoff_out_valid", 64'(out_valid), 64'd0);
        #1; auto_out = 1'b1;
        drain("alu_drain");

        // Request stalled, then reset while waiting for the response
        @(negedge clk); #3; auto_mem = 1'b0;
        @(negedge clk); mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        issue(OPC_LOAD, 3'b011, 64'h1000, 64'd0, 5'd7);
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("stall_req_valid", 64'(mem_req_valid), 64'd1);
            chk("stall_req_addr", mem_addr, 64'h1000);
            @(negedge clk);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2;
        chk("wait_req_valid", 64'(mem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        check_idle("rst_wait");
        @(negedge clk);
        rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("post_rst_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        #3; auto_mem = 1'b1;

`ifdef YSYX_22041412_LSU_MISALIGN_EN
        // Misaligned word load bypasses the bus
        push_out(64'h2, 5'd0, 1'b0, 1'b1);
        issue(OPC_LOAD, 3'b010, 64'h2, 64'd0, 5'd6);
        wait_out("mis_latency", 1);
        chk("mis_no_req", 64'(mem_req_valid), 64'd0);
        drain("mis_drain");
`endif

        // Randomized stream with bus and writeback backpressure
        rand_ready = 1'b1;
        extra_max = 2;
        for (int k = 0; k < 80; k++) begin
            a = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            rdat = {$urandom, $urandom};
            rd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0: begin
                    opc = ($urandom_range(0, 1) == 1) ? 7'b0110011 : OPC_ALU;
                    f3 = 3'($urandom_range(0, 7));
                end
                1: begin
                    opc = OPC_LOAD;
                    f3 = 3'($urandom_range(0, 6));
                end
                default: begin
                    opc = OPC_STORE;
                    f3 = 3'($urandom_range(0, 3));
                end
            endcase
            model(opc, f3, a, wd, rdat, rd);
            issue(opc, f3, a, wd, rd);
        end
        drain("random_drain");
        chk("req_queue_empty", 64'(exp_req.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
